// File: rtl/mesh_noc_pkg.sv
// Shared definitions for the mesh NoC resource-side packetizer:
// flit IDs, FSM states, field-width derivations and the head-flit layout.
package mesh_noc_pkg;

  localparam logic [1:0] FLIT_BODY      = 2'b00;
  localparam logic [1:0] FLIT_TAIL      = 2'b01;
  localparam logic [1:0] FLIT_HEAD      = 2'b10;
  localparam logic [1:0] FLIT_HEAD_TAIL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_SEND_HEAD    = 2'd1,
    ST_SEND_PAYLOAD = 2'd2
  } state_e;

  // Coordinate width is max(1, clog2(n)) so a 1x1 or 1xN mesh still has a field.
  function automatic int calc_coord_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int calc_len_w(input int max_flits);
    return $clog2(max_flits + 1);
  endfunction

  // Head data, LSB first: dst_col, dst_row, src_col, src_row, len; upper bits zero.
  function automatic logic [63:0] pack_head(
    input int          col_w,
    input int          row_w,
    input int          len_w,
    input logic [31:0] dst_col,
    input logic [31:0] dst_row,
    input logic [31:0] src_col,
    input logic [31:0] src_row,
    input logic [31:0] len
  );
    logic [63:0] f;
    int          sh;
    f  = '0;
    sh = 0;
    f  = f | ((64'(dst_col) & ((64'd1 << col_w) - 64'd1)) << sh);
    sh = sh + col_w;
    f  = f | ((64'(dst_row) & ((64'd1 << row_w) - 64'd1)) << sh);
    sh = sh + row_w;
    f  = f | ((64'(src_col) & ((64'd1 << col_w) - 64'd1)) << sh);
    sh = sh + col_w;
    f  = f | ((64'(src_row) & ((64'd1 << row_w) - 64'd1)) << sh);
    sh = sh + row_w;
    f  = f | ((64'(len) & ((64'd1 << len_w) - 64'd1)) << sh);
    return f;
  endfunction

endpackage

// File: rtl/mesh_noc_flit_reg.sv
// Registered valid/ready output stage; the held flit only changes when the
// stage is empty or its current flit is being accepted.
module mesh_noc_flit_reg
  import mesh_noc_pkg::*;
#(
  parameter int CHANNEL_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 vld_i,
  input  logic [CHANNEL_W-1:0] data_i,
  input  logic                 rdy_i,
  output logic                 vld_o,
  output logic [CHANNEL_W-1:0] data_o,
  output logic                 hs_o
);

  logic                 r_vld;
  logic [CHANNEL_W-1:0] r_data;
  logic                 w_free;

  assign w_free = !r_vld || rdy_i;
  assign hs_o   = r_vld && rdy_i;
  assign vld_o  = r_vld;
  assign data_o = r_data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else if (load_i && w_free) begin
      r_vld <= vld_i;
      if (vld_i) begin
        r_data <= data_i;
      end
    end
  end

endmodule

// File: rtl/mesh_noc_packetizer.sv
// Resource-side network interface: turns one whole message into a wormhole
// packet (head, optional bodies, tail) on a node's input channel.
module mesh_noc_packetizer
  import mesh_noc_pkg::*;
#(
  parameter int ROW_N             = 3,
  parameter int COL_M             = 3,
  parameter int SRC_ROW           = 0,
  parameter int SRC_COL           = 0,
  parameter int FLIT_ID_W         = 2,
  parameter int CHANNEL_W         = 16,
  parameter int MAX_PAYLOAD_FLITS = 4,
  parameter int CNT_W             = 16,
  localparam int ROW_W            = calc_coord_w(ROW_N),
  localparam int COL_W            = calc_coord_w(COL_M),
  localparam int LEN_W            = calc_len_w(MAX_PAYLOAD_FLITS),
  localparam int DATA_W           = CHANNEL_W - FLIT_ID_W,
  localparam int PAY_W            = MAX_PAYLOAD_FLITS * DATA_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ROW_W-1:0]     msg_dst_row_i,
  input  logic [COL_W-1:0]     msg_dst_col_i,
  input  logic [LEN_W-1:0]     msg_len_i,
  input  logic [PAY_W-1:0]     msg_data_i,
  input  logic                 msg_vld_i,
  output logic                 msg_rdy_o,
  output logic [CHANNEL_W-1:0] flit_data_o,
  output logic                 flit_vld_o,
  input  logic                 flit_rdy_i,
  output logic                 err_dst_o,
  output logic                 err_len_o,
  output logic [CNT_W-1:0]     pkt_cnt_o
);

  if (2*ROW_W + 2*COL_W + LEN_W > DATA_W) begin : g_bad_head_cfg
    $error("head fields do not fit in the flit data field");
  end
  if (FLIT_ID_W != 2) begin : g_bad_id_cfg
    $error("flit ID field must be 2 bits wide");
  end

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_TWO = LEN_W'(2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_PAYLOAD_FLITS);
  localparam logic [ROW_W:0]   ROW_LIM = (ROW_W+1)'(ROW_N);
  localparam logic [COL_W:0]   COL_LIM = (COL_W+1)'(COL_M);

  state_e             r_state;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_k;
  logic [PAY_W-1:0]   r_data;
  logic               r_err_dst;
  logic               r_err_len;
  logic [CNT_W-1:0]   r_pkt_cnt;

  logic               w_dst_ok;
  logic [LEN_W-1:0]   w_len_clamp;
  logic [DATA_W-1:0]  w_head;
  logic [LEN_W-1:0]   w_k_nxt;
  logic [PAY_W-1:0]   w_pay_shift;
  logic [DATA_W-1:0]  w_next_slice;
  logic               w_last;
  logic               w_hs;
  logic               w_load;
  logic               w_nvld;
  logic [CHANNEL_W-1:0] w_ndata;

  assign msg_rdy_o = (r_state == ST_IDLE) && !rst_i;
  assign err_dst_o = r_err_dst;
  assign err_len_o = r_err_len;
  assign pkt_cnt_o = r_pkt_cnt;

  assign w_dst_ok    = ({1'b0, msg_dst_row_i} < ROW_LIM) && ({1'b0, msg_dst_col_i} < COL_LIM);
  assign w_len_clamp = (msg_len_i > LEN_MAX) ? LEN_MAX : msg_len_i;
  assign w_head      = DATA_W'(pack_head(COL_W, ROW_W, LEN_W,
                                         32'(msg_dst_col_i), 32'(msg_dst_row_i),
                                         32'(SRC_COL), 32'(SRC_ROW), 32'(w_len_clamp)));

  // Slice to load next: slice 0 after the head, otherwise the one after k.
  assign w_k_nxt      = (r_state == ST_SEND_HEAD) ? '0 : r_k + LEN_ONE;
  assign w_pay_shift  = r_data >> (DATA_W * w_k_nxt);
  assign w_next_slice = w_pay_shift[DATA_W-1:0];
  assign w_last       = (r_k == r_len - LEN_ONE);

  always_comb begin
    w_load  = 1'b0;
    w_nvld  = 1'b0;
    w_ndata = '0;
    case (r_state)
      ST_IDLE: begin
        if (msg_vld_i && w_dst_ok) begin
          w_load  = 1'b1;
          w_nvld  = 1'b1;
          w_ndata = {(w_len_clamp == '0) ? FLIT_HEAD_TAIL : FLIT_HEAD, w_head};
        end
      end
      ST_SEND_HEAD: begin
        if (w_hs) begin
          w_load  = 1'b1;
          w_nvld  = (r_len != '0);
          w_ndata = {(r_len == LEN_ONE) ? FLIT_TAIL : FLIT_BODY, w_next_slice};
        end
      end
      ST_SEND_PAYLOAD: begin
        if (w_hs) begin
          w_load  = 1'b1;
          w_nvld  = !w_last;
          w_ndata = {(r_k + LEN_TWO == r_len) ? FLIT_TAIL : FLIT_BODY, w_next_slice};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_len     <= '0;
      r_k       <= '0;
      r_data    <= '0;
      r_err_dst <= 1'b0;
      r_err_len <= 1'b0;
      r_pkt_cnt <= '0;
    end else begin
      r_err_dst <= 1'b0;
      r_err_len <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (msg_vld_i) begin
            r_err_len <= (msg_len_i > LEN_MAX);
            if (w_dst_ok) begin
              r_len   <= w_len_clamp;
              r_data  <= msg_data_i;
              r_state <= ST_SEND_HEAD;
            end else begin
              r_err_dst <= 1'b1;
            end
          end
        end
        ST_SEND_HEAD: begin
          if (w_hs) begin
            r_k <= '0;
            if (r_len == '0) begin
              r_state   <= ST_IDLE;
              r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end else begin
              r_state <= ST_SEND_PAYLOAD;
            end
          end
        end
        ST_SEND_PAYLOAD: begin
          if (w_hs) begin
            if (w_last) begin
              r_state   <= ST_IDLE;
              r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end else begin
              r_k <= r_k + LEN_ONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  mesh_noc_flit_reg #(
    .CHANNEL_W (CHANNEL_W)
  ) u_flit_reg (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (w_load),
    .vld_i  (w_nvld),
    .data_i (w_ndata),
    .rdy_i  (flit_rdy_i),
    .vld_o  (flit_vld_o),
    .data_o (flit_data_o),
    .hs_o   (w_hs)
  );

endmodule
